// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: D-cache write-backs win outright, and the two line-read channels
// take turns on a tie. One line transaction is in flight at a time, and every output is registered.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_read_addr,
  output logic              ic_read_ack,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_read_addr,
  output logic              dc_read_ack,
  output logic [LINE_W-1:0] dc_read_data,
  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_write_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_write_ack,
  output logic              mem_enable,
  output logic              mem_rw,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic [LINE_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  typedef enum logic [1:0] {OWN_IC, OWN_DC, OWN_WR} owner_t;

  state_t state, state_next;
  owner_t owner;
  logic   rr_last;
  logic   grant_ic, grant_dc, grant_wr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    grant_ic   = 1'b0;
    grant_dc   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (dc_write_req) begin
          grant_wr = 1'b1;
        end else if (ic_read_req && dc_read_req) begin
          grant_ic = rr_last;
          grant_dc = ~rr_last;
        end else begin
          grant_ic = ic_read_req;
          grant_dc = dc_read_req;
        end
        if (grant_ic || grant_dc || grant_wr) state_next = MEM;
      end
      MEM:     if (mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner        <= OWN_IC;
      rr_last      <= 1'b0;
      mem_enable   <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      ic_read_ack  <= 1'b0;
      dc_read_ack  <= 1'b0;
      dc_write_ack <= 1'b0;
      ic_read_data <= '0;
      dc_read_data <= '0;
    end else begin
      ic_read_ack  <= 1'b0;
      dc_read_ack  <= 1'b0;
      dc_write_ack <= 1'b0;
      mem_enable   <= (state_next == MEM);

      // The memory side is driven only from these registers, so it ignores requester changes mid-flight.
      if (grant_wr) begin
        owner        <= OWN_WR;
        mem_rw       <= 1'b1;
        mem_addr     <= dc_write_addr;
        mem_data_out <= dc_write_data;
      end
      if (grant_ic) begin
        owner    <= OWN_IC;
        mem_rw   <= 1'b0;
        mem_addr <= ic_read_addr;
        rr_last  <= 1'b0;
      end
      if (grant_dc) begin
        owner    <= OWN_DC;
        mem_rw   <= 1'b0;
        mem_addr <= dc_read_addr;
        rr_last  <= 1'b1;
      end

      if (state == MEM && mem_ack) begin
        case (owner)
          OWN_IC: begin
            ic_read_ack  <= 1'b1;
            ic_read_data <= mem_data_in;
          end
          OWN_DC: begin
            dc_read_ack  <= 1'b1;
            dc_read_data <= mem_data_in;
          end
          default: dc_write_ack <= 1'b1;
        endcase
      end
    end
  end

endmodule
